// File: rtl/float_pkg.sv
// Shared definitions for the 8-bit {exp[7:5], man[4:0]} float format and the
// accumulator FSM state encoding.
package float_pkg;
  localparam int EXP_W   = 3;
  localparam int MAN_W   = 5;
  localparam int FLOAT_W = 8;
  localparam logic [FLOAT_W-1:0] FLOAT_MAX = 8'hFF;
  localparam logic [EXP_W-1:0]   EXP_ONE   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/float_add.sv
// Combinational adder for the 8-bit float format: align the smaller operand
// by truncating right shift, add, renormalise on carry, saturate to FLOAT_MAX.
module float_add
  import float_pkg::*;
(
  input  logic [FLOAT_W-1:0] aIn,
  input  logic [FLOAT_W-1:0] bIn,
  output logic [FLOAT_W-1:0] result
);

  logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_diff;
  logic [MAN_W-1:0] man_a, man_b, man_big, man_small, man_shift;
  logic [MAN_W:0]   man_sum;

  always_comb begin
    exp_a = aIn[FLOAT_W-1:MAN_W];
    exp_b = bIn[FLOAT_W-1:MAN_W];
    man_a = aIn[MAN_W-1:0];
    man_b = bIn[MAN_W-1:0];
    if (exp_a >= exp_b) begin
      exp_big   = exp_a;
      man_big   = man_a;
      man_small = man_b;
      exp_diff  = exp_a - exp_b;
    end else begin
      exp_big   = exp_b;
      man_big   = man_b;
      man_small = man_a;
      exp_diff  = exp_b - exp_a;
    end
    man_shift = man_small >> exp_diff;
    man_sum   = {1'b0, man_big} + {1'b0, man_shift};
    // Carry out of the mantissa: drop the LSB and bump the exponent, or clip.
    if (man_sum[MAN_W]) begin
      if (exp_big == {EXP_W{1'b1}}) result = FLOAT_MAX;
      else                          result = {exp_big + EXP_ONE, man_sum[MAN_W:1]};
    end else begin
      result = {exp_big, man_sum[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/float_accum.sv
// Packet accumulator: sums float samples until in_last, then holds the sum,
// sample count and saturation flag until the consumer takes them.
module float_accum
  import float_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOAT_W-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [FLOAT_W-1:0] out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [FLOAT_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               rdy_q;
  logic [FLOAT_W-1:0] add_res;
  logic               accept;

  float_add u_add (
    .aIn    (sum_q),
    .bIn    (in_data),
    .result (add_res)
  );

  assign accept = in_valid && in_ready;

  // rdy_q holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sum_d   = in_data;
          cnt_d   = CNT_ONE;
          sat_d   = (in_data == FLOAT_MAX);
          state_d = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          sum_d   = add_res;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_ONE;
          sat_d   = sat_q | (add_res == FLOAT_MAX);
          state_d = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rdy_q && (state_q != ST_DONE);
    out_valid = (state_q == ST_DONE);
    out_data  = sum_q;
    out_count = cnt_q;
    out_sat   = sat_q;
  end

endmodule

// File: tb/tb_float_accum.sv
// Self-checking bench for float_accum: expected packet results are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_float_accum;
  import float_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       out_sat, out_valid, out_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] count;
    logic       sat;
  } res_t;

  res_t exp_q[$];

  float_accum #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int ea, ma, eb, mb, e, m;
    ea = a[7:5]; ma = a[4:0];
    eb = b[7:5]; mb = b[4:0];
    if (ea >= eb) begin e = ea; m = ma + (mb >> (ea - eb)); end
    else          begin e = eb; m = mb + (ma >> (eb - ea)); end
    if (m > 31) begin m = m / 2; e = e + 1; end
    if (e > 7) return 8'hFF;
    return {e[2:0], m[4:0]};
  endfunction

  task automatic drive_sample(input logic [7:0] d, input logic last, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_latency(input string name);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_latency: out_valid=%b required 1 one cycle after last", name, out_valid);
    end
  endtask

  task automatic collect(input string name);
    int t;
    res_t e;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    n_checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_result: out_valid=%b queued=%0d required a pending result", name, out_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    if (out_data !== e.data) begin
      n_errors++;
      $display("FAIL %s_data: got %h required %h", name, out_data, e.data);
    end
    n_checks++;
    if (out_count !== e.count) begin
      n_errors++;
      $display("FAIL %s_count: got %0d required %0d", name, out_count, e.count);
    end
    n_checks++;
    if (out_sat !== e.sat) begin
      n_errors++;
      $display("FAIL %s_sat: got %b required %b", name, out_sat, e.sat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_take: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_count !== 4'd0 || out_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%0d sat=%b required 0/0/00/0/0",
               in_ready, out_valid, out_data, out_count, out_sat);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_rdy: in_ready=%b required 0 before first edge", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_edge_rdy: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    exp_q.push_back('{8'h50, 4'd3, 1'b0});
    drive_sample(8'h10, 1'b0, 0);
    drive_sample(8'h10, 1'b0, 0);
    drive_sample(8'h30, 1'b1, 0);
    check_latency("basic");
    collect("basic");
  endtask

  task automatic test_align();
    exp_q.push_back('{8'h94, 4'd1, 1'b0});
    drive_sample(8'h94, 1'b1, 0);
    check_latency("one_sample");
    collect("one_sample");
    exp_q.push_back('{8'h92, 4'd2, 1'b0});
    drive_sample(8'h90, 1'b0, 0);
    drive_sample(8'h30, 1'b1, 0);
    collect("align");
  endtask

  task automatic test_saturation();
    exp_q.push_back('{8'hFF, 4'd2, 1'b1});
    drive_sample(8'hF0, 1'b0, 0);
    drive_sample(8'hF0, 1'b1, 0);
    collect("sat");
    exp_q.push_back('{8'hF8, 4'd2, 1'b0});
    drive_sample(8'hF0, 1'b0, 0);
    drive_sample(8'hD0, 1'b1, 0);
    collect("no_sat");
  endtask

  task automatic test_backpressure();
    res_t e;
    e = '{8'h04, 4'd2, 1'b0};
    exp_q.push_back(e);
    drive_sample(8'h03, 1'b0, 0);
    drive_sample(8'h01, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data ||
          out_count !== e.count || out_sat !== e.sat) begin
        n_errors++;
        $display("FAIL hold_%0d: vld=%b rdy=%b data=%h cnt=%0d sat=%b required 1/0/%h/%0d/%b",
                 i, out_valid, in_ready, out_data, out_count, out_sat, e.data, e.count, e.sat);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    collect("hold");
  endtask

  task automatic test_gaps();
    exp_q.push_back('{8'h50, 4'd3, 1'b0});
    drive_sample(8'h10, 1'b0, 2);
    drive_sample(8'h10, 1'b0, 2);
    drive_sample(8'h30, 1'b1, 2);
    check_latency("gaps");
    collect("gaps");
    exp_q.push_back('{8'h11, 4'd15, 1'b0});
    for (int i = 0; i < 17; i++) drive_sample(8'h01, (i == 16), 0);
    collect("count_sat");
  endtask

  task automatic test_reset_mid();
    drive_sample(8'h30, 1'b0, 0);
    drive_sample(8'h30, 1'b0, 0);
    @(negedge clk); rst_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_count !== 4'd0 || out_data !== 8'h00) begin
        n_errors++;
        $display("FAIL mid_reset_%0d: vld=%b rdy=%b cnt=%0d data=%h required 0/0/0/00",
                 i, out_valid, in_ready, out_count, out_data);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_vld_%0d: out_valid=%b required 0", i, out_valid);
      end
    end
    exp_q.push_back('{8'h30, 4'd1, 1'b0});
    drive_sample(8'h30, 1'b1, 0);
    check_latency("after_reset");
    collect("after_reset");
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int         len;
      logic [7:0] d, s;
      logic       sat;
      int         cnt;
      len = $urandom_range(1, 6);
      d = 8'($urandom_range(0, 255));
      s = d; sat = (d == 8'hFF); cnt = 1;
      for (int k = 1; k < len; k++) begin
        d = 8'($urandom_range(0, 255));
        s = ref_add(s, d);
        sat = sat | (s == 8'hFF);
        cnt++;
      end
      exp_q.push_back('{s, 4'(cnt), sat});
      // Regenerate identical samples from the same seed order is not possible,
      // so replay them from a stored list instead.
    end
  endtask

  task automatic test_random_packets();
    logic [7:0] samples[$];
    for (int p = 0; p < 6; p++) begin
      int         len;
      logic [7:0] s;
      logic       sat;
      samples.delete();
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) samples.push_back(8'($urandom_range(0, 255)));
      s = samples[0]; sat = (s == 8'hFF);
      for (int k = 1; k < len; k++) begin
        s = ref_add(s, samples[k]);
        sat = sat | (s == 8'hFF);
      end
      exp_q.push_back('{s, 4'(len), sat});
      for (int k = 0; k < len; k++)
        drive_sample(samples[k], (k == len - 1), $urandom_range(0, 1));
      collect("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_align();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_random_packets();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_results: %0d queued required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/float_accum.md
FLOAT_ACCUM -- requirements
Module: float_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the sample-count output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_data, input, 8 bits: operand, float format {exp[7:5], man[4:0]}, value = man × 2^exp.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-006 SHALL have port in_last, input, 1 bit: the current sample closes the packet.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 SHALL have port out_data, output, 8 bits: packet sum, same float format.
REQ-009 SHALL have port out_count, output, CNT_W bits: samples accepted in the packet.
REQ-010 SHALL have port out_sat, output, 1 bit: the sum reached 8'hFF at some point in the packet.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data, out_count and out_sat are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-013 A sample SHALL be accepted on any rising edge where in_valid && in_ready; a result SHALL be taken on any rising edge where out_valid && out_ready.
REQ-014 FSM SHALL have three states: IDLE (no open packet), ACCUM (packet open), DONE (result held).
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE and while rst_n is low; out_valid SHALL be 1 only in DONE.
REQ-016 On accept in IDLE: sum <= in_data, count <= 1, sat <= (in_data == 8'hFF); next state DONE if in_last, else ACCUM.
REQ-017 On accept in ACCUM: sum <= float_add(sum, in_data); count <= count+1, saturating at 2^CNT_W−1; sat <= sat | (new sum == 8'hFF); next state DONE if in_last, else stay in ACCUM.
REQ-018 No accept in IDLE/ACCUM SHALL leave all state unchanged (in_valid gaps allowed mid-packet).
REQ-019 Addition SHALL be float_add semantics: exponent alignment with truncation, renormalisation, saturation to 8'hFF; the block SHALL NOT add independent rounding.
REQ-020 Latency: the result SHALL be visible on out_* the cycle after the in_last sample is accepted.
REQ-021 In DONE, out_data/out_count/out_sat SHALL stay stable until taken; on take the FSM SHALL go to IDLE, and in_ready SHALL be 1 in the following cycle.
REQ-022 in_valid SHALL be ignored in DONE; in_last on the first sample SHALL give a one-sample packet with sum = in_data.
REQ-023 out_data, out_count and out_sat SHALL be driven directly from registers, with no combinational path from in_* to out_*.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, sum 8'h00, count 0, sat 0, out_valid 0, in_ready 0.
REQ-025 Reset mid-packet or in DONE SHALL discard the partial or held result; no out_valid pulse after release until a new packet completes.
REQ-026 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-027 Shared package float_pkg SHALL hold EXP_W=3, MAN_W=5, FLOAT_W=8, FLOAT_MAX=8'hFF and the FSM state enumeration.
REQ-028 The block SHALL instantiate exactly one existing combinational float_add (aIn=sum, bIn=in_data, result) as its sole sub-module.

Verification
REQ-029 Packet 000_10000, 000_10000, 001_10000(last) -> out_data 010_10000, out_count 3, out_sat 0, out_valid 1 cycle after the last accept.
REQ-030 One-sample packet 100_10100(last) -> out_data 100_10100, out_count 1; packet 100_10000, 001_10000(last) -> 100_10010.
REQ-031 Packet 111_10000, 111_10000(last) -> out_data 111_11111, out_sat 1; packet 111_10000, 110_10000(last) -> 111_11000, out_sat 0.
REQ-032 out_ready held 0 for 3 cycles in DONE -> out_* stable, in_ready 0, in_valid ignored; take -> IDLE, in_ready 1 next cycle.
REQ-033 in_valid gaps of 2 cycles mid-packet -> same sum as the gap-free case; 17 samples of 000_00001 -> out_count 15.
REQ-034 rst_n pulsed low after 2 samples of an open packet -> out_valid 0, in_ready 0 during reset; next packet 001_10000(last) -> out_data 001_10000, out_count 1.
